// File: rtl/char_display_ram_arb_if.sv
// char_display_ram_arb_if
//   Bundles the three requesters of the character RAM:
//     VGA   : vga_en, vga_col, vga_row -> vga_data
//     CPU   : cpu_req, cpu_we, cpu_col, cpu_row, cpu_wdata -> cpu_ack, cpu_rdata, cpu_err
//     clear : clr_start, clr_fill -> clr_busy
//   master : requester side (drives requests, receives results)
//   slave  : the arbiter/RAM side
interface char_display_ram_arb_if #(
    parameter int DATA_W = 6,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 6
);
    logic              vga_en;
    logic [COL_W-1:0]  vga_col;
    logic [ROW_W-1:0]  vga_row;
    logic [DATA_W-1:0] vga_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [COL_W-1:0]  cpu_col;
    logic [ROW_W-1:0]  cpu_row;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              clr_start;
    logic [DATA_W-1:0] clr_fill;
    logic              clr_busy;

    modport master (
        output vga_en, vga_col, vga_row,
        output cpu_req, cpu_we, cpu_col, cpu_row, cpu_wdata,
        output clr_start, clr_fill,
        input  vga_data, cpu_ack, cpu_rdata, cpu_err, clr_busy
    );

    modport slave (
        input  vga_en, vga_col, vga_row,
        input  cpu_req, cpu_we, cpu_col, cpu_row, cpu_wdata,
        input  clr_start, clr_fill,
        output vga_data, cpu_ack, cpu_rdata, cpu_err, clr_busy
    );
endinterface

// File: rtl/char_display_ram_arb.sv
// char_display_ram_arb
//   Single-port COLS x ROWS character RAM shared by a VGA reader, an optional
//   clear engine and a CPU. One access per cycle, fixed priority
//   VGA > clear > CPU. Linear address = row*COLS + col.
//
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : char_display_ram_arb_if.slave (VGA, CPU and clear signals)
//
// Build option
//   CHARRAM_CLEAR_EN : when defined, the clear engine is built. Otherwise the
//                      clr_* inputs are ignored, clr_busy is tied low and the
//                      arbitration reduces to VGA > CPU.
//
// Clear FSM
//   state | meaning
//   IDLE  | no sweep; clr_start launches one
//   SWEEP | writing fill to cnt, advancing on every cycle VGA leaves the port free
module char_display_ram_arb #(
    parameter int DATA_W = 6,
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int COL_W  = $clog2(COLS),
    parameter int ROW_W  = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    char_display_ram_arb_if.slave bus
);
    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);

    // Contents are deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] cpu_addr;
    logic              vga_in_range;
    logic              cpu_in_range;

    assign vga_addr     = ADDR_W'(bus.vga_row) * ADDR_W'(COLS) + ADDR_W'(bus.vga_col);
    assign cpu_addr     = ADDR_W'(bus.cpu_row) * ADDR_W'(COLS) + ADDR_W'(bus.cpu_col);
    assign vga_in_range = (int'(bus.vga_col) < COLS) && (int'(bus.vga_row) < ROWS);
    assign cpu_in_range = (int'(bus.cpu_col) < COLS) && (int'(bus.cpu_row) < ROWS);

    logic              clr_active;   // sweep in progress
    logic              clr_launch;   // sweep starts at the coming edge
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

`ifdef CHARRAM_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_e;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [DATA_W-1:0] clr_fill_q;
    logic              clr_busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_fill_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_q    <= SWEEP;
                        clr_busy_q <= 1'b1;
                        clr_cnt_q  <= '0;
                        clr_fill_q <= bus.clr_fill;
                    end
                end
                SWEEP: begin
                    // VGA owns the port this cycle: hold position.
                    if (!bus.vga_en) begin
                        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                            state_q    <= IDLE;
                            clr_busy_q <= 1'b0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_active   = (state_q == SWEEP);
    // A CPU request seen together with clr_start waits until after the sweep,
    // so its write cannot be overwritten by the fill.
    assign clr_launch   = (state_q == IDLE) && bus.clr_start;
    assign clr_addr     = clr_cnt_q;
    assign clr_data     = clr_fill_q;
    assign bus.clr_busy = clr_busy_q;
`else
    logic unused_clr;
    assign unused_clr   = bus.clr_start ^ (^bus.clr_fill);
    assign clr_active   = 1'b0;
    assign clr_launch   = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign bus.clr_busy = 1'b0;
`endif

    logic vga_gnt;
    logic clr_gnt;
    logic cpu_gnt;
    logic cpu_ack_q;

    assign vga_gnt = bus.vga_en;
    assign clr_gnt = clr_active && !vga_gnt;
    // cpu_ack_q blocks the still-held request from being granted a second time.
    assign cpu_gnt = bus.cpu_req && !vga_gnt && !clr_active && !clr_launch && !cpu_ack_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = bus.cpu_wdata;
        if (clr_gnt) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = clr_data;
        end else if (cpu_gnt && bus.cpu_we && cpu_in_range) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] vga_data_d;
    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_err_q;

    always_comb begin
        vga_data_d = '0;
        if (vga_in_range) begin
            vga_data_d = mem[vga_addr];
        end
        cpu_rdata_d = '0;
        if (cpu_in_range) begin
            cpu_rdata_d = bus.cpu_we ? bus.cpu_wdata : mem[cpu_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else begin
            if (vga_gnt) begin
                vga_data_q <= vga_data_d;
            end
            cpu_ack_q <= cpu_gnt;
            if (cpu_gnt) begin
                cpu_rdata_q <= cpu_rdata_d;
                cpu_err_q   <= !cpu_in_range;
            end
        end
    end

    assign bus.vga_data  = vga_data_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_err   = cpu_err_q;
endmodule
